// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional build macro: SEQ_DIVIDER_SIGNED_EN (adds two's-complement mode).
package seq_divider_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Quotient reported for a zero divisor; sliced to the operand width by users.
  localparam logic [MAX_WIDTH-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider.
// Optional build macro: SEQ_DIVIDER_SIGNED_EN (adds the sgn request bit).
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
);

  logic             go;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             sgn;
`endif
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             err;

`ifdef SEQ_DIVIDER_SIGNED_EN
  modport master (output go, x, y, sgn, input quotient, remainder, busy, done, err);
  modport slave  (input go, x, y, sgn, output quotient, remainder, busy, done, err);
`else
  modport master (output go, x, y, input quotient, remainder, busy, done, err);
  modport slave  (input go, x, y, output quotient, remainder, busy, done, err);
`endif

endinterface

// File: rtl/seq_divider_dp.sv
// Divider datapath: operand capture, restoring shift-subtract, counter, sign fix-up.
// Signed operation is only requested when SEQ_DIVIDER_SIGNED_EN is defined at the top.
module seq_divider_dp
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start_c,
  input  logic             step_c,
  input  logic             load_c,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sgn,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz,
  output logic             last_c
);

  localparam int unsigned      CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] part;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;

  logic             x_neg;
  logic             y_neg;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] part_nx;
  logic [WIDTH-1:0] rem_src;

  // One restoring step; dividend bits shift out of quo as quotient bits shift in.
  always_comb begin
    x_neg   = sgn & x[WIDTH-1];
    y_neg   = sgn & y[WIDTH-1];
    trial   = {part, quo[WIDTH-1]};
    fits    = (trial >= {1'b0, divisor});
    part_nx = fits ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];
    rem_src = dz ? quo : part;
    last_c  = (cnt == CNT_LAST);
  end

  // Magnitudes are divided; signs are restored when the result is loaded.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      divisor   <= '0;
      quo       <= '0;
      part      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (start_c) begin
        divisor <= y_neg ? negate(y) : y;
        quo     <= x_neg ? negate(x) : x;
        part    <= '0;
        cnt     <= '0;
        neg_q   <= x_neg ^ y_neg;
        neg_r   <= x_neg;
        dz      <= (y == '0);
      end else if (step_c) begin
        quo  <= {quo[WIDTH-2:0], fits};
        part <= part_nx;
        cnt  <= cnt + CNT_ONE;
      end
      if (load_c) begin
        quotient  <= dz ? DZ_QUOTIENT[WIDTH-1:0] : (neg_q ? negate(quo) : quo);
        remainder <= neg_r ? negate(rem_src) : rem_src;
      end
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: IDLE/DIV/DONE control around seq_divider_dp.
// Optional build macro: SEQ_DIVIDER_SIGNED_EN (two's-complement mode via bus.sgn).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          CLK,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  state_t state;
  state_t state_nx;

  logic start_c;
  logic step_c;
  logic load_c;
  logic busy_nx;
  logic done_nx;
  logic err_nx;
  logic sgn_c;
  logic dz;
  logic last_c;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign sgn_c = bus.sgn;
`else
  assign sgn_c = 1'b0;
`endif

  // State register and registered status flags.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.busy <= busy_nx;
      bus.done <= done_nx;
      bus.err  <= err_nx;
    end
  end

  // Next state; a zero divisor skips the iterations entirely.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (bus.go) state_nx = (bus.y == '0) ? ST_DONE : ST_DIV;
      ST_DIV:  if (last_c) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath controls and next values of the status flags.
  always_comb begin
    start_c = 1'b0;
    step_c  = 1'b0;
    load_c  = 1'b0;
    done_nx = 1'b0;
    err_nx  = 1'b0;
    busy_nx = (state_nx == ST_DIV);
    unique case (state)
      ST_IDLE: start_c = bus.go;
      ST_DIV:  step_c  = 1'b1;
      ST_DONE: begin
        load_c  = 1'b1;
        done_nx = 1'b1;
        err_nx  = dz;
      end
      default: ;
    endcase
  end

  seq_divider_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .CLK       (CLK),
    .rst       (rst),
    .start_c   (start_c),
    .step_c    (step_c),
    .load_c    (load_c),
    .x         (bus.x),
    .y         (bus.y),
    .sgn       (sgn_c),
    .quotient  (bus.quotient),
    .remainder (bus.remainder),
    .dz        (dz),
    .last_c    (last_c)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8) against an arithmetic reference model.
// Signed cases are exercised when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; SV signed division truncates toward zero.
  task automatic ref_div(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [7:0] q, output logic [7:0] r, output logic e);
    int sa;
    int sb;
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
      e = 1'b1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = 8'(sa / sb);
      r  = 8'(sa % sb);
      e  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      e = 1'b0;
    end
  endtask

  // Called just after the accepting edge; counts edges until done shows up.
  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) bcyc++;
      check("err_before_done", {31'd0, bus.err}, 32'd0);
      tick;
      lat++;
    end
    if (lat >= 40) check("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [7:0] eq;
    logic [7:0] er;
    logic       ee;
    int         lat;
    int         bc;
    ref_div(a, b, s, eq, er, ee);
    bus.x  = a;
    bus.y  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
    bus.sgn = s;
`endif
    bus.go = 1'b1;
    tick;
    bus.go = 1'b0;
    bus.x  = 8'($urandom);
    bus.y  = 8'($urandom);
    wait_done(lat, bc);
    check("latency", 32'(lat), (b == 8'd0) ? 32'd1 : 32'd9);
    check("busy_cycles", 32'(bc), (b == 8'd0) ? 32'd0 : 32'd8);
    check("busy_with_done", {31'd0, bus.busy}, 32'd0);
    check("quotient", 32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("err", {31'd0, bus.err}, {31'd0, ee});
    tick;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("err_one_cycle", {31'd0, bus.err}, 32'd0);
  endtask

  initial begin
    int lat;
    int bc;
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    int sq;
    int sb;
    int sr;

    rst    = 1'b0;
    bus.go = 1'b0;
    bus.x  = '0;
    bus.y  = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    bus.sgn = 1'b0;
`endif
    tick;
    tick;
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b1;
    tick;

    // Basic unsigned case with known answer.
    run_op(8'd200, 8'd7, 1'b0);
    check("q_200_7", 32'(bus.quotient), 32'd28);
    check("r_200_7", 32'(bus.remainder), 32'd4);

    // go held high: second request during DIV is ignored, restart after done.
    bus.x  = 8'd255;
    bus.y  = 8'd1;
    bus.go = 1'b1;
    tick;
    bus.x = 8'd0;
    bus.y = 8'd9;
    wait_done(lat, bc);
    check("b2b_lat1", 32'(lat), 32'd9);
    check("b2b_busy1", 32'(bc), 32'd8);
    check("b2b_q1", 32'(bus.quotient), 32'd255);
    check("b2b_r1", 32'(bus.remainder), 32'd0);
    tick;
    check("b2b_restart", {31'd0, bus.busy}, 32'd1);
    bus.go = 1'b0;
    wait_done(lat, bc);
    check("b2b_lat2", 32'(lat), 32'd9);
    check("b2b_q2", 32'(bus.quotient), 32'd0);
    check("b2b_r2", 32'(bus.remainder), 32'd0);
    tick;

    // Divide by zero, then results must hold.
    run_op(8'd55, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("dz_hold_q", 32'(bus.quotient), 32'd255);
      check("dz_hold_r", 32'(bus.remainder), 32'd55);
      check("dz_hold_err", {31'd0, bus.err}, 32'd0);
    end

    // Reset in the 4th DIV cycle aborts with no done.
    bus.x  = 8'd200;
    bus.y  = 8'd7;
    bus.go = 1'b1;
    tick;
    bus.go = 1'b0;
    tick;
    tick;
    tick;
    check("abort_in_div", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_q", 32'(bus.quotient), 32'd0);
    check("abort_r", 32'(bus.remainder), 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_err", {31'd0, bus.err}, 32'd0);
    tick;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      check("abort_no_done", {31'd0, bus.done}, 32'd0);
      check("abort_idle", {31'd0, bus.busy}, 32'd0);
    end
    run_op(8'd9, 8'd3, 1'b0);
    check("q_9_3", 32'(bus.quotient), 32'd3);
    check("r_9_3", 32'(bus.remainder), 32'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(8'hF9, 8'h02, 1'b1);
    check("s_q_m7_2", 32'(bus.quotient), 32'h0000_00FD);
    check("s_r_m7_2", 32'(bus.remainder), 32'h0000_00FF);
    run_op(8'h80, 8'hFF, 1'b1);
    check("s_q_ovf", 32'(bus.quotient), 32'h0000_0080);
    check("s_r_ovf", 32'(bus.remainder), 32'd0);
`endif

    // Randomized operands against the reference model plus algebraic identities.
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
`ifdef SEQ_DIVIDER_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run_op(a, b, s);
      if (b != 8'd0) begin
        if (!s) begin
          check("rem_lt_y", {31'd0, (bus.remainder < b)}, 32'd1);
          check("identity", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
        end else begin
          sq = int'($signed(bus.quotient));
          sb = int'($signed(b));
          sr = int'($signed(bus.remainder));
          check("s_identity", 32'(8'(sq * sb + sr)), 32'(a));
          check("s_rem_mag", {31'd0, ((sr < 0 ? -sr : sr) < (sb < 0 ? -sb : sb))}, 32'd1);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
